// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 receiver state encodings, prefix bytes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer, glitch filter and falling-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_fall
);

    localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILTER_LEN - 1);

    logic [1:0]         r_sync_q;
    logic [1:0]         w_sync_d;
    logic               r_level_q;
    logic               w_level_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        w_sync_d  = {r_sync_q[0], i_line};
        w_level_d = r_level_q;
        w_cnt_d   = '0;
        if (r_sync_q[1] != r_level_q) begin
            if (r_cnt_q == c_CNT_MAX) begin
                w_level_d = r_sync_q[1];
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q  <= 2'b11;
            r_level_q <= 1'b1;
            r_cnt_q   <= '0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_level_q <= w_level_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_fall = r_level_q & ~w_level_d;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_receiver
// Description : PS/2 keyboard frame receiver with E0/F0 prefix decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       ext,
    output logic       brk,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic               w_clk_fall;
    logic [1:0]         r_data_sync_q;
    logic               w_data_bit;

    logic [1:0]         r_state_q,    w_state_d;
    logic [7:0]         r_shift_q,    w_shift_d;
    logic [2:0]         r_bit_q,      w_bit_d;
    logic               r_par_q,      w_par_d;
    logic [c_TMO_W-1:0] r_tmo_q,      w_tmo_d;
    logic               r_ext_pend_q, w_ext_pend_d;
    logic               r_brk_pend_q, w_brk_pend_d;
    logic [7:0]         r_code_q,     w_code_d;
    logic               r_ext_q,      w_ext_d;
    logic               r_brk_q,      w_brk_d;
    logic               r_valid_q,    w_valid_d;
    logic               r_perr_q,     w_perr_d;
    logic               r_ferr_q,     w_ferr_d;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .i_line (kbd_clk),
        .o_fall (w_clk_fall)
    );

    assign w_data_bit = r_data_sync_q[1];

    always_comb begin
        w_state_d    = r_state_q;
        w_shift_d    = r_shift_q;
        w_bit_d      = r_bit_q;
        w_par_d      = r_par_q;
        w_tmo_d      = '0;
        w_ext_pend_d = r_ext_pend_q;
        w_brk_pend_d = r_brk_pend_q;
        w_code_d     = r_code_q;
        w_ext_d      = r_ext_q;
        w_brk_d      = r_brk_q;
        w_valid_d    = 1'b0;
        w_perr_d     = 1'b0;
        w_ferr_d     = 1'b0;

        if (w_clk_fall) begin
            case (r_state_q)
                c_ST_IDLE: begin
                    if (!w_data_bit) begin
                        w_state_d = c_ST_DATA;
                        w_bit_d   = 3'd0;
                    end else begin
                        w_ferr_d     = 1'b1;
                        w_ext_pend_d = 1'b0;
                        w_brk_pend_d = 1'b0;
                    end
                end
                c_ST_DATA: begin
                    w_shift_d = {w_data_bit, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + 3'd1;
                    if (r_bit_q == 3'd7) begin
                        w_state_d = c_ST_PARITY;
                    end
                end
                c_ST_PARITY: begin
                    w_par_d   = w_data_bit;
                    w_state_d = c_ST_STOP;
                end
                default: begin
                    // Stop bit: a bad stop bit masks any parity failure.
                    w_state_d = c_ST_IDLE;
                    if (!w_data_bit) begin
                        w_ferr_d     = 1'b1;
                        w_ext_pend_d = 1'b0;
                        w_brk_pend_d = 1'b0;
                    end else if (!odd_parity_ok(r_shift_q, r_par_q)) begin
                        w_perr_d     = 1'b1;
                        w_ext_pend_d = 1'b0;
                        w_brk_pend_d = 1'b0;
                    end else if (r_shift_q == PS2_EXT) begin
                        w_ext_pend_d = 1'b1;
                    end else if (r_shift_q == PS2_BRK) begin
                        w_brk_pend_d = 1'b1;
                    end else begin
                        w_code_d     = r_shift_q;
                        w_ext_d      = r_ext_pend_q;
                        w_brk_d      = r_brk_pend_q;
                        w_valid_d    = 1'b1;
                        w_ext_pend_d = 1'b0;
                        w_brk_pend_d = 1'b0;
                    end
                end
            endcase
        end else if (r_state_q != c_ST_IDLE) begin
            if (r_tmo_q == c_TMO_LAST) begin
                w_state_d    = c_ST_IDLE;
                w_ferr_d     = 1'b1;
                w_ext_pend_d = 1'b0;
                w_brk_pend_d = 1'b0;
            end else begin
                w_tmo_d = r_tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_sync_q <= 2'b11;
            r_state_q     <= c_ST_IDLE;
            r_shift_q     <= 8'h00;
            r_bit_q       <= 3'd0;
            r_par_q       <= 1'b0;
            r_tmo_q       <= '0;
            r_ext_pend_q  <= 1'b0;
            r_brk_pend_q  <= 1'b0;
            r_code_q      <= 8'h00;
            r_ext_q       <= 1'b0;
            r_brk_q       <= 1'b0;
            r_valid_q     <= 1'b0;
            r_perr_q      <= 1'b0;
            r_ferr_q      <= 1'b0;
        end else begin
            r_data_sync_q <= {r_data_sync_q[0], kbd_data};
            r_state_q     <= w_state_d;
            r_shift_q     <= w_shift_d;
            r_bit_q       <= w_bit_d;
            r_par_q       <= w_par_d;
            r_tmo_q       <= w_tmo_d;
            r_ext_pend_q  <= w_ext_pend_d;
            r_brk_pend_q  <= w_brk_pend_d;
            r_code_q      <= w_code_d;
            r_ext_q       <= w_ext_d;
            r_brk_q       <= w_brk_d;
            r_valid_q     <= w_valid_d;
            r_perr_q      <= w_perr_d;
            r_ferr_q      <= w_ferr_d;
        end
    end

    assign code       = r_code_q;
    assign ext        = r_ext_q;
    assign brk        = r_brk_q;
    assign code_valid = r_valid_q;
    assign parity_err = r_perr_q;
    assign frame_err  = r_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_receiver
// Description : Scoreboard bench for ps2_kbd_receiver with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_receiver;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 25;

    localparam logic [1:0] K_CODE = 2'd0;
    localparam logic [1:0] K_PERR = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_clk = 1'b1;
    logic       kbd_data = 1'b1;
    logic [7:0] code;
    logic       code_valid, ext, brk, parity_err, frame_err;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    logic [7:0] last_code = 8'h00;
    logic       last_ext = 1'b0;
    logic       last_brk = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kbd_clk    (kbd_clk),
        .kbd_data   (kbd_data),
        .code       (code),
        .code_valid (code_valid),
        .ext        (ext),
        .brk        (brk),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // Monitor: pops one expectation per output pulse and checks hold behaviour.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] got;
        if (rst) begin
            last_code = 8'h00;
            last_ext  = 1'b0;
            last_brk  = 1'b0;
        end else begin
            if (code_valid || parity_err || frame_err) begin
                checks++;
                got = code_valid ? K_CODE : (parity_err ? K_PERR : K_FERR);
                if ($countones({code_valid, parity_err, frame_err}) > 1) begin
                    errors++;
                    $display("FAIL exclusive: got valid=%0b perr=%0b ferr=%0b, expected at most one",
                             code_valid, parity_err, frame_err);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d at %0t, expected none", got, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e.kind) begin
                        errors++;
                        $display("FAIL event_kind: got kind=%0d, expected kind=%0d at %0t",
                                 got, e.kind, $time);
                    end else if (got == K_CODE && {code, ext, brk} != {e.code, e.ext, e.brk}) begin
                        errors++;
                        $display("FAIL code_event: got code=%02h ext=%0b brk=%0b, expected code=%02h ext=%0b brk=%0b",
                                 code, ext, brk, e.code, e.ext, e.brk);
                    end
                end
            end
            if (code_valid) begin
                last_code = code;
                last_ext  = ext;
                last_brk  = brk;
            end else begin
                checks++;
                if ({code, ext, brk} != {last_code, last_ext, last_brk}) begin
                    errors++;
                    $display("FAIL hold: got code=%02h ext=%0b brk=%0b, expected code=%02h ext=%0b brk=%0b",
                             code, ext, brk, last_code, last_ext, last_brk);
                end
            end
        end
    end

    task automatic push_err(input logic [1:0] kind);
        exp_t e;
        e = '{kind: kind, code: 8'h00, ext: 1'b0, brk: 1'b0};
        exp_q.push_back(e);
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // Reference model of one complete frame as seen from the keyboard side.
    task automatic model_frame(input logic [7:0] b, input bit par, input bit stp);
        exp_t e;
        if (!stp) begin
            push_err(K_FERR);
        end else if ((($countones(b) + int'(par)) % 2) == 0) begin
            push_err(K_PERR);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e = '{kind: K_CODE, code: b, ext: m_ext, brk: m_brk};
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit v);
        kbd_data = v;
        wait_n(HALF);
        kbd_clk = 1'b0;
        wait_n(HALF);
        kbd_clk = 1'b1;
    endtask

    function automatic bit good_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par, input bit stp, input int glitch_after);
        logic [7:0] bb;
        bb = b;
        model_frame(bb, par, stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(bb[i]);
            if (i == glitch_after) begin
                wait_n(2 * FILTER_LEN);
                kbd_clk = 1'b0;
                wait_n(3);
                kbd_clk = 1'b1;
            end
        end
        send_bit(par);
        send_bit(stp);
        kbd_data = 1'b1;
        wait_n(4 * HALF);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, good_par(b), 1'b1, -1);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({code, ext, brk, code_valid, parity_err, frame_err} != 13'd0) begin
            errors++;
            $display("FAIL %s: got code=%02h ext=%0b brk=%0b valid=%0b perr=%0b ferr=%0b, expected all zero",
                     name, code, ext, brk, code_valid, parity_err, frame_err);
        end
    endtask

    // Start bit plus four data bits, then the clock stops low-then-high.
    task automatic timeout_test();
        logic [7:0] b;
        int  n;
        bit  seen;
        b = 8'h2D;
        push_err(K_FERR);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        kbd_data = b[3];
        wait_n(HALF);
        kbd_clk = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT_CYCLES + FILTER_LEN + 100) begin
            @(posedge clk);
            n++;
            #1;
            if (n == HALF) kbd_clk = 1'b1;
            if (frame_err) seen = 1'b1;
        end
        kbd_data = 1'b1;
        checks++;
        if (!seen || n != TIMEOUT_CYCLES + FILTER_LEN + 2) begin
            errors++;
            $display("FAIL timeout_latency: got seen=%0b cycles=%0d, expected cycles=%0d",
                     seen, n, TIMEOUT_CYCLES + FILTER_LEN + 2);
        end
        wait_n(4 * HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit par, stp;
        rst = 1'b1;
        wait_n(5);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        wait_n(20);

        send_good(8'h1C);
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'h1C);

        send_good(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_good(8'h1C);

        send_good(8'hF0);
        model_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1);
        kbd_data = 1'b1;
        wait_n(4 * HALF);
        send_good(8'h1C);

        send_frame(8'h33, good_par(8'h33), 1'b0, -1);
        send_frame(8'h33, ~good_par(8'h33), 1'b0, -1);

        send_good(8'hE0);
        timeout_test();
        send_good(8'h1C);

        send_frame(8'h5A, good_par(8'h5A), 1'b1, 3);

        send_good(8'hE0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        kbd_data = 1'b1;
        wait_n(10);
        rst = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_n(5);
        check_outputs_zero("mid_frame_reset");
        rst = 1'b0;
        wait_n(20);
        send_good(8'h1C);

        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            par = ($urandom_range(0, 7) == 0) ? ~good_par(b) : good_par(b);
            stp = ($urandom_range(0, 9) != 0);
            send_frame(b, par, stp, -1);
        end

        wait_n(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_receiver.md
PS2_KBD_RECEIVER -- requirements
Module: ps2_kbd_receiver

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 8, number of consecutive equal synchronized samples needed to accept a new kbd_clk level.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 65535, clk cycles without a filtered kbd_clk falling edge before an in-progress frame is aborted.
REQ-003 SHALL provide port clk  input  1  system clock; sole clock of the block.
REQ-004 SHALL provide port rst  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL provide port kbd_clk  input  1  PS/2 keyboard clock, asynchronous, idle high.
REQ-006 SHALL provide port kbd_data  input  1  PS/2 keyboard data, asynchronous, idle high.
REQ-007 SHALL provide port code  output  8  last accepted scan code, excluding E0/F0 prefixes.
REQ-008 SHALL provide port code_valid  output  1  one-cycle pulse; code, ext and brk are valid in that cycle.
REQ-009 SHALL provide port ext  output  1  an E0 prefix preceded code.
REQ-010 SHALL provide port brk  output  1  an F0 prefix preceded code (key release).
REQ-011 SHALL provide port parity_err  output  1  one-cycle pulse on odd-parity failure.
REQ-012 SHALL provide port frame_err  output  1  one-cycle pulse on a bad start or stop bit, or on timeout.

Function
REQ-013 SHALL pass kbd_clk and kbd_data through two-flop synchronizers before any other use.
REQ-014 SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronized samples, so pulses shorter than FILTER_LEN cycles are ignored.
REQ-015 SHALL sample synchronized kbd_data in the cycle the filtered clock falls (1->0).
REQ-016 SHALL run state machine IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing one state per sampled bit; DATA consumes exactly 8 bits.
REQ-017 SHALL, in IDLE, enter DATA on a sampled 0 (start bit) and otherwise stay in IDLE and pulse frame_err.
REQ-018 SHALL shift data bits LSB first into an 8-bit register, using a 3-bit bit counter.
REQ-019 SHALL require XOR of the 8 data bits and the parity bit to equal 1 (odd parity).
REQ-020 SHALL, on a STOP sample of 1 with good parity, complete the frame: emit or absorb the byte per REQ-022..REQ-024 one clk after the stop edge.
REQ-021 SHALL, when the stop bit is 0, pulse frame_err, return to IDLE and drop the byte; with a stop bit of 1 and bad parity it SHALL pulse parity_err and drop the byte; if both fail, only frame_err SHALL pulse.
REQ-022 SHALL, for byte 0xE0, set the pending-ext flag with no code_valid.
REQ-023 SHALL, for byte 0xF0, set the pending-brk flag with no code_valid.
REQ-024 SHALL, for any other byte, drive code = byte, ext and brk = pending flags, pulse code_valid, and clear both pending flags in that cycle.
REQ-025 SHALL hold code, ext and brk stable between code_valid pulses.
REQ-026 SHALL clear the pending prefix flags on any parity_err or frame_err.
REQ-027 SHALL, outside IDLE, count clk cycles since the last filtered falling edge, restart the count on every such edge, and at TIMEOUT_CYCLES pulse frame_err and return to IDLE.
REQ-028 SHALL never assert code_valid, parity_err and frame_err in the same cycle.

Reset
REQ-029 SHALL, while rst=1, enter IDLE, set synchronizer and filter state to 1, clear counters, shift register and pending flags, and drive code=0x00 and ext, brk, code_valid, parity_err, frame_err = 0.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first frame after release decodes normally.

Structure
REQ-031 SHALL place state encodings and constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0 in shared package ps2_pkg.
REQ-032 SHALL implement synchronizer, glitch filter and falling-edge detector as sub-module ps2_line_filter, instantiated once for kbd_clk; kbd_data SHALL use only the synchronizer.

Verification
REQ-033 SHALL cover: frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one code_valid, code=0x1C, ext=0, brk=0.
REQ-034 SHALL cover: F0 then 1C -> single code_valid with code=0x1C, brk=1, ext=0; no pulse after the F0 frame.
REQ-035 SHALL cover: E0, F0, 75 -> code=0x75, ext=1, brk=1; the next frame 0x1C gives ext=0, brk=0.
REQ-036 SHALL cover: 0x1C with parity 1 -> parity_err for one cycle, no code_valid, pending flags cleared.
REQ-037 SHALL cover: clock stopped after 4 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last edge; the next full frame 0x1C decodes correctly.
REQ-038 SHALL cover: 3-cycle low glitch on kbd_clk with FILTER_LEN=8 -> no bit sampled, state unchanged; rst=1 mid-frame -> all outputs 0, next frame correct.
